sram_ctrl: RTL and testbench

//   AXI4-Lite slave controller that sequences a single-port synchronous SRAM macro behind the xbar s0 port.

---
 rtl/sram_ctrl_pkg.sv | 16 +
 rtl/sram_ctrl_rr.sv | 14 +
 rtl/sram_ctrl.sv | 140 ++++++++++++++
 tb/tb_sram_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared widths, AXI response codes and request direction type for the SRAM controller.
package sram_ctrl_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int STRB_W = DATA_W / 8;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic {
        DIR_RD = 1'b0,
        DIR_WR = 1'b1
    } dir_e;

endpackage

// File: rtl/sram_ctrl_rr.sv
// Two-way round-robin picker between the read and write channels; the history bit lives in the caller.
module sram_ctrl_rr (
    input  logic rd_req,
    input  logic wr_req,
    input  logic last_wr,
    output logic grant_rd,
    output logic grant_wr
);

    // On contention the side that did not win last time goes first.
    assign grant_wr = wr_req & (~rd_req | ~last_wr);
    assign grant_rd = rd_req & (~wr_req | last_wr);

endmodule

// File: rtl/sram_ctrl.sv
// AXI4-Lite slave that serialises read and write channels onto one single-port synchronous SRAM.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE   = 32'h8000_0000,
    parameter int          MEM_AW = 12,
    parameter int          LAT    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] araddr,
    input  logic              arvalid,
    output logic              arready,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        rresp,
    output logic              rvalid,
    input  logic              rready,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic              awvalid,
    output logic              awready,
    input  logic [DATA_W-1:0] wdata,
    input  logic [STRB_W-1:0] wstrb,
    input  logic              wvalid,
    output logic              wready,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready,
    output logic              mem_en,
    output logic [STRB_W-1:0] mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    function automatic logic in_window(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1:MEM_AW+2] == BASE[ADDR_W-1:MEM_AW+2];
    endfunction

    logic [1:0]        state;
    logic              last_wr;
    logic              grant_rd;
    logic              grant_wr;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] hs_addr;
    logic              unused_addr_lsbs;

    logic [MEM_AW-1:0] addr_p0;
    logic [DATA_W-1:0] wdata_p0;
    logic [STRB_W-1:0] wstrb_p0;
    dir_e              dir_p0;

    sram_ctrl_rr u_rr (
        .rd_req   (arvalid),
        .wr_req   (awvalid & wvalid),
        .last_wr  (last_wr),
        .grant_rd (grant_rd),
        .grant_wr (grant_wr)
    );

    assign hs_addr          = grant_wr ? awaddr : araddr;
    assign unused_addr_lsbs = ^hs_addr[1:0];

    // Readys are offered only from IDLE, so a response handshake can never chain into a new accept.
    assign arready = (state == ST_IDLE) & ~rst & grant_rd;
    assign awready = (state == ST_IDLE) & ~rst & grant_wr;
    assign wready  = awready;

    assign mem_en    = (state == ST_ACCESS);
    assign mem_we    = (state == ST_ACCESS && dir_p0 == DIR_WR) ? wstrb_p0 : '0;
    assign mem_addr  = addr_p0;
    assign mem_wdata = wdata_p0;

    assign rvalid = (state == ST_RESP) & (dir_p0 == DIR_RD);
    assign bvalid = (state == ST_RESP) & (dir_p0 == DIR_WR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            last_wr <= 1'b0;
            cnt     <= '0;
            rdata   <= '0;
            rresp   <= AXI_RESP_OKAY;
            bresp   <= AXI_RESP_OKAY;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_rd | grant_wr) begin
                        addr_p0  <= hs_addr[MEM_AW+1:2];
                        wdata_p0 <= wdata;
                        wstrb_p0 <= wstrb;
                        dir_p0   <= grant_wr ? DIR_WR : DIR_RD;
                        last_wr  <= grant_wr;
                        if (in_window(hs_addr)) begin
                            state <= ST_ACCESS;
                        end else begin
                            // Decode miss: skip the SRAM entirely and answer with SLVERR.
                            state <= ST_RESP;
                            if (grant_wr) begin
                                bresp <= AXI_RESP_SLVERR;
                            end else begin
                                rresp <= AXI_RESP_SLVERR;
                                rdata <= '0;
                            end
                        end
                    end
                end
                ST_ACCESS: begin
                    if (dir_p0 == DIR_WR) begin
                        bresp <= AXI_RESP_OKAY;
                        state <= ST_RESP;
                    end else begin
                        cnt   <= 4'(LAT - 1);
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt == 4'd0) begin
                        rdata <= mem_rdata;
                        rresp <= AXI_RESP_OKAY;
                        state <= ST_RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    if ((dir_p0 == DIR_WR && bready) || (dir_p0 == DIR_RD && rready)) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl: one instance with LAT=1, one with LAT=4, each held in reset while the other runs.
module tb_sram_ctrl;

    logic        clk = 1'b0;
    logic        rst_a, rst_b;
    logic [31:0] araddr, awaddr, wdata;
    logic        arvalid, rready, awvalid, wvalid, bready;
    logic [3:0]  wstrb;

    logic        arready_a, rvalid_a, awready_a, wready_a, bvalid_a, mem_en_a;
    logic [31:0] rdata_a, mem_wdata_a, mem_rdata_a;
    logic [1:0]  rresp_a, bresp_a;
    logic [3:0]  mem_we_a;
    logic [11:0] mem_addr_a;

    logic        arready_b, rvalid_b, awready_b, wready_b, bvalid_b, mem_en_b;
    logic [31:0] rdata_b, mem_wdata_b, mem_rdata_b;
    logic [1:0]  rresp_b, bresp_b;
    logic [3:0]  mem_we_b;
    logic [11:0] mem_addr_b;
    logic [31:0] pipe_b [0:3];

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sram_ctrl #(.BASE(32'h8000_0000), .MEM_AW(12), .LAT(1)) dut_a (
        .clk(clk), .rst(rst_a),
        .araddr(araddr), .arvalid(arvalid), .arready(arready_a),
        .rdata(rdata_a), .rresp(rresp_a), .rvalid(rvalid_a), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready_a),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready_a),
        .bresp(bresp_a), .bvalid(bvalid_a), .bready(bready),
        .mem_en(mem_en_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a),
        .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a)
    );

    sram_ctrl #(.BASE(32'h8000_0000), .MEM_AW(12), .LAT(4)) dut_b (
        .clk(clk), .rst(rst_b),
        .araddr(araddr), .arvalid(arvalid), .arready(arready_b),
        .rdata(rdata_b), .rresp(rresp_b), .rvalid(rvalid_b), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready_b),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready_b),
        .bresp(bresp_b), .bvalid(bvalid_b), .bready(bready),
        .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
        .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b)
    );

    // SRAM models: data is A5000000|word_addr exactly LAT cycles after mem_en, garbage otherwise.
    always_ff @(posedge clk) begin
        mem_rdata_a <= mem_en_a ? (32'hA500_0000 | {20'd0, mem_addr_a}) : 32'hBAD0_BAD0;
        pipe_b[0]   <= mem_en_b ? (32'hA500_0000 | {20'd0, mem_addr_b}) : 32'hBAD0_BAD0;
        pipe_b[1]   <= pipe_b[0];
        pipe_b[2]   <= pipe_b[1];
        pipe_b[3]   <= pipe_b[2];
    end
    assign mem_rdata_b = pipe_b[3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        araddr = 32'h8000_0010; arvalid = 1'b1;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
        rready = 1'b1; bready = 1'b1;

        // Reset state, with a read request pending to show reset masks arready
        repeat (3) @(negedge clk);
        #1;
        chk("rst_arready", arready_a, 0);
        chk("rst_rvalid", rvalid_a, 0);
        chk("rst_bvalid", bvalid_a, 0);
        chk("rst_mem_en", mem_en_a, 0);
        chk("rst_mem_we", mem_we_a, 0);
        chk("rst_rdata", rdata_a, 0);
        chk("rst_resps", {rresp_a, bresp_a}, 0);
        arvalid = 1'b0;
        @(negedge clk);
        rst_a = 1'b0;

        // Write 0x8000_0008, last_wr 0 -> 1
        @(negedge clk);
        awaddr = 32'h8000_0008; wdata = 32'hDEAD_BEEF; wstrb = 4'b0011;
        awvalid = 1'b1; wvalid = 1'b1;
        #1;
        chk("wr_c0_awready", awready_a, 1);
        chk("wr_c0_wready", wready_a, 1);
        chk("wr_c0_arready", arready_a, 0);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        #1;
        chk("wr_c1_mem_en", mem_en_a, 1);
        chk("wr_c1_mem_we", mem_we_a, 4'b0011);
        chk("wr_c1_mem_addr", mem_addr_a, 12'd2);
        chk("wr_c1_mem_wdata", mem_wdata_a, 32'hDEAD_BEEF);
        chk("wr_c1_bvalid", bvalid_a, 0);
        @(negedge clk);
        chk("wr_c2_bvalid", bvalid_a, 1);
        chk("wr_c2_bresp", bresp_a, 2'b00);
        chk("wr_c2_mem_en", mem_en_a, 0);
        @(negedge clk);
        chk("wr_c3_bvalid", bvalid_a, 0);

        // Read 0x8000_0010, last_wr 1 -> 0
        araddr = 32'h8000_0010; arvalid = 1'b1;
        #1;
        chk("rd_c0_arready", arready_a, 1);
        chk("rd_c0_awready", awready_a, 0);
        @(negedge clk);
        arvalid = 1'b0;
        #1;
        chk("rd_c1_mem_en", mem_en_a, 1);
        chk("rd_c1_mem_addr", mem_addr_a, 12'd4);
        chk("rd_c1_mem_we", mem_we_a, 0);
        @(negedge clk);
        chk("rd_c2_rvalid", rvalid_a, 0);
        chk("rd_c2_mem_en", mem_en_a, 0);
        @(negedge clk);
        chk("rd_c3_rvalid", rvalid_a, 1);
        chk("rd_c3_rdata", rdata_a, 32'hA500_0004);
        chk("rd_c3_rresp", rresp_a, 2'b00);
        @(negedge clk);
        chk("rd_c4_rvalid", rvalid_a, 0);

        // Both sides requesting: write wins first (last_wr=0), then read
        araddr = 32'h8000_0030; awaddr = 32'h8000_000C;
        wdata = 32'h1111_2222; wstrb = 4'b1111;
        arvalid = 1'b1; awvalid = 1'b1; wvalid = 1'b1;
        #1;
        chk("arb1_awready", awready_a, 1);
        chk("arb1_arready", arready_a, 0);
        @(negedge clk);
        chk("arb1_mem_we", mem_we_a, 4'b1111);
        chk("arb1_mem_addr", mem_addr_a, 12'd3);
        @(negedge clk);
        chk("arb1_bvalid", bvalid_a, 1);
        @(negedge clk);
        #1;
        chk("arb2_arready", arready_a, 1);
        chk("arb2_awready", awready_a, 0);
        @(negedge clk);
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        #1;
        chk("arb2_mem_en", mem_en_a, 1);
        chk("arb2_mem_addr", mem_addr_a, 12'd12);
        chk("arb2_mem_we", mem_we_a, 0);
        repeat (2) @(negedge clk);
        chk("arb2_rvalid", rvalid_a, 1);
        chk("arb2_rdata", rdata_a, 32'hA500_000C);
        @(negedge clk);
        chk("arb2_rvalid_done", rvalid_a, 0);

        // AW without W: no readys until W arrives
        awaddr = 32'h8000_0100; wdata = 32'hCAFE_F00D; wstrb = 4'b1100;
        awvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("lone_aw_readys", {awready_a, wready_a, arready_a}, 0);
            @(negedge clk);
        end
        wvalid = 1'b1;
        #1;
        chk("lone_aw_both_ready", {awready_a, wready_a}, 2'b11);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        #1;
        chk("lone_aw_mem_we", mem_we_a, 4'b1100);
        chk("lone_aw_mem_addr", mem_addr_a, 12'h040);
        chk("lone_aw_mem_wdata", mem_wdata_a, 32'hCAFE_F00D);
        @(negedge clk);
        chk("lone_aw_bvalid", bvalid_a, 1);
        @(negedge clk);

        // Out-of-window read with rready held low
        rready = 1'b0; araddr = 32'h1000_0000; arvalid = 1'b1;
        #1;
        chk("err_rd_arready", arready_a, 1);
        @(negedge clk);
        arvalid = 1'b0;
        #1;
        chk("err_rd_c1_rvalid", rvalid_a, 1);
        chk("err_rd_c1_rresp", rresp_a, 2'b10);
        chk("err_rd_c1_rdata", rdata_a, 0);
        chk("err_rd_c1_mem_en", mem_en_a, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("err_rd_hold", {rvalid_a, rresp_a, mem_en_a, rdata_a}, {1'b1, 2'b10, 1'b0, 32'h0});
        end
        rready = 1'b1;
        @(negedge clk);
        chk("err_rd_done", rvalid_a, 0);

        // First address past the window: write gets SLVERR
        awaddr = 32'h8000_4000; wdata = 32'h5555_AAAA; wstrb = 4'b1111;
        awvalid = 1'b1; wvalid = 1'b1;
        #1;
        chk("err_wr_awready", awready_a, 1);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        #1;
        chk("err_wr_bvalid", bvalid_a, 1);
        chk("err_wr_bresp", bresp_a, 2'b10);
        chk("err_wr_mem_en", mem_en_a, 0);
        @(negedge clk);
        chk("err_wr_done", bvalid_a, 0);

        // Last word of the window, byte offset ignored
        araddr = 32'h8000_3FFF; arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        #1;
        chk("top_rd_mem_en", mem_en_a, 1);
        chk("top_rd_mem_addr", mem_addr_a, 12'hFFF);
        repeat (2) @(negedge clk);
        chk("top_rd_rvalid", rvalid_a, 1);
        chk("top_rd_rresp", rresp_a, 2'b00);
        chk("top_rd_rdata", rdata_a, 32'hA500_0FFF);
        @(negedge clk);

        // LAT=4 instance: reset during WAIT drops the read
        rst_a = 1'b1; rst_b = 1'b0;
        araddr = 32'h8000_0020; arvalid = 1'b1;
        #1;
        chk("b_c0_arready", arready_b, 1);
        @(negedge clk);
        arvalid = 1'b0;
        #1;
        chk("b_c1_mem_en", mem_en_b, 1);
        chk("b_c1_mem_addr", mem_addr_b, 12'd8);
        repeat (3) @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        #1;
        chk("b_rst_rvalid", rvalid_b, 0);
        chk("b_rst_mem_en", mem_en_b, 0);
        chk("b_rst_rdata", rdata_b, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("b_rst_no_resp", {rvalid_b, mem_en_b}, 0);
        end

        // Following read completes with rvalid at c6
        araddr = 32'h8000_0024; arvalid = 1'b1;
        #1;
        chk("b2_c0_arready", arready_b, 1);
        @(negedge clk);
        arvalid = 1'b0;
        #1;
        chk("b2_c1_mem_en", mem_en_b, 1);
        repeat (4) @(negedge clk);
        chk("b2_c5_rvalid", rvalid_b, 0);
        @(negedge clk);
        chk("b2_c6_rvalid", rvalid_b, 1);
        chk("b2_c6_rdata", rdata_b, 32'hA500_0009);
        chk("b2_c6_rresp", rresp_b, 2'b00);
        @(negedge clk);
        chk("b2_c7_rvalid", rvalid_b, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
